battle_sequencer: RTL and testbench
===================================

// Module: battle_sequencer
// PURPOSE
//  Top-level turn scheduler for the battle screen. Drives the shared 4-bit state bus read by player (attack
//  phase) and the enemy attack block, waits for each block's finished_out handshake, checks HP-zero flags and
//  advances IDLE -> PLAYER_ATK -> ENEMY_ATK -> ... -> WIN/LOSE. All state changes align to frame start.
// PARAMETERS
//  TIMEOUT_FRAMES  1800  frames a phase may run before forced advance (0 disables watchdog)
//  MAX_TURNS       8     enemy attacks survived before WIN by endurance (1..255)
// PORTS
//  clk                 in   1   pixel clock
//  rst                 in   1   reset, asynchronous, active-high
//  hcount_in           in   11  current pixel column
//  vcount_in           in   10  current pixel row
//  start_in            in   1   1-cycle pulse: leave IDLE / restart from WIN or LOSE
//  player_finished_in  in   1   player finished_out; held high until state_out leaves PLAYER_ATK
//  enemy_finished_in   in   1   enemy attack block finished; same hold rule for ENEMY_ATK
//  enemy_hp_zero_in    in   1   level: enemy health bar empty
//  player_hp_zero_in   in   1   level: player HP empty
//  state_out           out  4   registered phase code (game_pkg encoding)
//  turn_out            out  8   completed enemy-attack count, saturates at 255
//  timeout_out         out  1   1-cycle pulse when watchdog forces an advance
//  game_over_out       out  1   high while state_out is WIN or LOSE
// BEHAVIOUR
//  - frame_tick = (hcount_in==0 && vcount_in==0), combinational. Every state_out change happens on a clk edge
//    where frame_tick=1; nothing else moves state_out.
//  - Reset (async): state_out=IDLE(4'b0000), turn_out=0, timeout_out=0, game_over_out=0, done latch=0,
//    frame counter=0. Mid-phase reset returns to IDLE immediately; blocks see the state change and abort.
//  - done latch: set when current phase's finished input is 1; cleared on every state_out change.
//    Finished input for the other phase is ignored.
//  - start latch: start_in pulse sets it in IDLE/WIN/LOSE; consumed at next frame_tick. Ignored elsewhere.
//  - States / transitions (evaluated only at frame_tick, priority top-down):
//    IDLE(0000):       start latch -> PLAYER_ATK.
//    PLAYER_ATK(0001): done & enemy_hp_zero -> WIN; done | watchdog -> ENEMY_ATK.
//    ENEMY_ATK(0010):  player_hp_zero (any time) -> LOSE; done | watchdog -> turn_out+=1, then
//                      (turn_out+1 >= MAX_TURNS) ? WIN : PLAYER_ATK.
//    WIN(0100), LOSE(0101): hold; start latch -> IDLE with turn_out=0.
//  - Entry to PLAYER_ATK/ENEMY_ATK is always from a different code, so player's old_state edge detect fires.
//  - Watchdog: frame counter clears on state change, +1 per frame_tick in attack phases; expires when
//    count == TIMEOUT_FRAMES-1 at a frame_tick -> advance as if done, timeout_out=1 for that one cycle.
//    If done and expiry coincide, treat as done; timeout_out stays 0.
//  - game_over_out registered, updates same edge as state_out. turn_out saturates (no wrap at 255).
//  - Latency: finished seen in frame N -> state_out changes at the first frame_tick at/after it (<=1 frame).
// STRUCTURE
//  - game_pkg: typedef enum logic[3:0] phase_t {IDLE,PLAYER_ATK,ENEMY_ATK,WIN,LOSE} with codes above;
//    constants FRAME_H=1344, FRAME_V=806 for bench frame synthesis. Shared with player / enemy blocks.
//  - One sub-module: frame_watchdog (clk, rst, clear, tick, expire) parameterised by TIMEOUT_FRAMES.
//  - FSM + latches in one always_ff; next-state in always_comb.
// TESTING
//  - Reset mid-ENEMY_ATK: assert rst any cycle -> state_out=0000, turn_out=0 with no clock edge needed.
//  - start_in pulse at hcount=500 -> state_out 0000->0001 exactly at next hcount=0,vcount=0 edge.
//  - PLAYER_ATK, player_finished_in=1 at frame 3, enemy_hp_zero=0 -> 0010 at frame 4 tick; done cleared.
//  - player_finished_in=1 with enemy_hp_zero=1 -> 0100, game_over_out=1; start_in -> 0000, turn_out=0.
//  - TIMEOUT_FRAMES=4, no finished -> advance at 4th tick, timeout_out single-cycle 1; coincident done -> 0.
//  - MAX_TURNS=2: two enemy finishes -> turn_out=2, state 0100; player_hp_zero in ENEMY_ATK -> 0101.

Source files
------------

// File: rtl/game_pkg.sv
// Shared battle-screen phase encoding and frame geometry, used by the sequencer and the attack blocks.
// Latency: n/a (types, constants and helpers only).
// Backpressure: n/a.
package game_pkg;

    typedef enum logic [3:0] {
        IDLE       = 4'b0000,
        PLAYER_ATK = 4'b0001,
        ENEMY_ATK  = 4'b0010,
        WIN        = 4'b0100,
        LOSE       = 4'b0101
    } phase_t;

    // Full frame size in pixel clocks, including blanking
    localparam int FRAME_H = 1344;
    localparam int FRAME_V = 806;

    // Phases in which an attack block is running and the watchdog counts
    function automatic logic is_attack(input phase_t p);
        return (p == PLAYER_ATK) || (p == ENEMY_ATK);
    endfunction

    // Phases that accept a start pulse
    function automatic logic is_rest(input phase_t p);
        return (p == IDLE) || (p == WIN) || (p == LOSE);
    endfunction

endpackage

// File: rtl/frame_watchdog.sv
// Counts frame ticks since the last clear and flags the tick on which the phase has run too long.
// Latency: expire is combinational on the TIMEOUT_FRAMES-th tick after a clear.
// Backpressure: none; clear has priority over counting.
module frame_watchdog #(
    parameter int TIMEOUT_FRAMES = 1800
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic tick,
    output logic expire
);

    localparam int CW      = (TIMEOUT_FRAMES > 1) ? $clog2(TIMEOUT_FRAMES) : 1;
    localparam bit ENABLED = (TIMEOUT_FRAMES != 0);
    localparam int LAST_I  = ENABLED ? (TIMEOUT_FRAMES - 1) : 0;
    localparam logic [CW-1:0] LAST = CW'(LAST_I);

    logic [CW-1:0] count;

    // Frame counter: restarts on every phase change, advances on each counted tick
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (tick) begin
            count <= count + 1'b1;
        end
    end

    // A zero timeout turns the watchdog off entirely
    assign expire = ENABLED && tick && (count == LAST);

endmodule

// File: rtl/battle_sequencer.sv
// Turn scheduler for the battle screen: drives the shared phase bus and advances on finished/HP/watchdog events.
// Latency: state changes only on a frame-start edge, at most one frame after the triggering event.
// Backpressure: none; finished inputs are level-held by the blocks, start is latched until the next frame start.
module battle_sequencer
    import game_pkg::*;
#(
    parameter int TIMEOUT_FRAMES = 1800,
    parameter int MAX_TURNS      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic        start_in,
    input  logic        player_finished_in,
    input  logic        enemy_finished_in,
    input  logic        enemy_hp_zero_in,
    input  logic        player_hp_zero_in,
    output logic [3:0]  state_out,
    output logic [7:0]  turn_out,
    output logic        timeout_out,
    output logic        game_over_out
);

    phase_t     state_q;
    phase_t     state_nxt;
    logic [7:0] turn_nxt;
    logic       timeout_nxt;
    logic       done_q;
    logic       start_q;
    logic       frame_tick;
    logic       cur_fin;
    logic       done_eff;
    logic       start_eff;
    logic       state_chg;
    logic       wd_expire;

    assign frame_tick = (hcount_in == 11'd0) && (vcount_in == 10'd0);

    // Only the finished input belonging to the running phase counts
    assign cur_fin = ((state_q == PLAYER_ATK) && player_finished_in) ||
                     ((state_q == ENEMY_ATK)  && enemy_finished_in);

    // A finish or start arriving on the frame-start cycle itself is honoured immediately
    assign done_eff  = done_q || cur_fin;
    assign start_eff = start_q || (start_in && is_rest(state_q));
    assign state_chg = (state_nxt != state_q);
    assign state_out = state_q;

    frame_watchdog #(
        .TIMEOUT_FRAMES(TIMEOUT_FRAMES)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (state_chg),
        .tick   (frame_tick && is_attack(state_q)),
        .expire (wd_expire)
    );

    // Next phase, turn count and timeout flag; everything holds except on a frame start
    always_comb begin
        state_nxt   = state_q;
        turn_nxt    = turn_out;
        timeout_nxt = 1'b0;
        if (frame_tick) begin
            case (state_q)
                IDLE: begin
                    if (start_eff) state_nxt = PLAYER_ATK;
                end
                PLAYER_ATK: begin
                    if (done_eff && enemy_hp_zero_in) begin
                        state_nxt = WIN;
                    end else if (done_eff || wd_expire) begin
                        state_nxt   = ENEMY_ATK;
                        timeout_nxt = !done_eff;
                    end
                end
                ENEMY_ATK: begin
                    if (player_hp_zero_in) begin
                        state_nxt = LOSE;
                    end else if (done_eff || wd_expire) begin
                        turn_nxt    = (turn_out == 8'hFF) ? turn_out : turn_out + 8'd1;
                        timeout_nxt = !done_eff;
                        // Surviving the last allowed enemy attack wins by endurance
                        state_nxt   = (({1'b0, turn_out} + 9'd1) >= 9'(MAX_TURNS)) ? WIN : PLAYER_ATK;
                    end
                end
                WIN, LOSE: begin
                    if (start_eff) begin
                        state_nxt = IDLE;
                        turn_nxt  = 8'd0;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // Phase register, registered outputs, and the done/start latches
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            turn_out      <= 8'd0;
            timeout_out   <= 1'b0;
            game_over_out <= 1'b0;
            done_q        <= 1'b0;
            start_q       <= 1'b0;
        end else begin
            state_q       <= state_nxt;
            turn_out      <= turn_nxt;
            timeout_out   <= timeout_nxt;
            game_over_out <= (state_nxt == WIN) || (state_nxt == LOSE);
            if (state_chg) begin
                done_q <= 1'b0;
            end else if (cur_fin) begin
                done_q <= 1'b1;
            end
            if (frame_tick) begin
                start_q <= 1'b0;
            end else if (start_in && is_rest(state_q)) begin
                start_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_battle_sequencer.sv
// Randomized scoreboard bench for battle_sequencer on a scaled-down frame.
// Latency: each predicted phase change is tagged with the clock edge on which it must appear.
// Backpressure: n/a.
module tb_battle_sequencer;
    import game_pkg::*;

    localparam int TO   = 4;
    localparam int MT   = 3;
    localparam int H    = FRAME_H / 64;   // 21 columns
    localparam int V    = FRAME_V / 200;  // 4 rows
    localparam int NCYC = 16000;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] hcount_in;
    logic [9:0]  vcount_in;
    logic        start_in;
    logic        player_finished_in;
    logic        enemy_finished_in;
    logic        enemy_hp_zero_in;
    logic        player_hp_zero_in;
    logic [3:0]  state_out;
    logic [7:0]  turn_out;
    logic        timeout_out;
    logic        game_over_out;

    always #5 clk = ~clk;

    battle_sequencer #(
        .TIMEOUT_FRAMES(TO),
        .MAX_TURNS     (MT)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .hcount_in         (hcount_in),
        .vcount_in         (vcount_in),
        .start_in          (start_in),
        .player_finished_in(player_finished_in),
        .enemy_finished_in (enemy_finished_in),
        .enemy_hp_zero_in  (enemy_hp_zero_in),
        .player_hp_zero_in (player_hp_zero_in),
        .state_out         (state_out),
        .turn_out          (turn_out),
        .timeout_out       (timeout_out),
        .game_over_out     (game_over_out)
    );

    typedef struct {
        int         cyc;
        logic [3:0] st;
        logic [7:0] turn;
        logic       to;
        logic       go;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: current phase, turns survived, whether a finish was seen this phase,
    // frame starts elapsed since the phase began, and a pending start request
    phase_t m_ph;
    int     m_turn;
    bit     m_seen;
    bit     m_start;
    int     m_frames;
    bit     pf_on, ef_on;
    int     hc, vc;

    task automatic model_reset();
        m_ph = IDLE; m_turn = 0; m_seen = 0; m_start = 0; m_frames = 0;
        pf_on = 0; ef_on = 0;
    endtask

    task automatic predict();
        bit tick, fin, done, startq, attack, expired;
        phase_t nx;
        int nt;
        bit to;
        exp_t e;
        tick   = (hc == 0) && (vc == 0);
        fin    = (m_ph == PLAYER_ATK) ? player_finished_in :
                 (m_ph == ENEMY_ATK)  ? enemy_finished_in  : 1'b0;
        done   = m_seen || fin;
        startq = m_start || (start_in && (m_ph == IDLE || m_ph == WIN || m_ph == LOSE));
        if (!tick) begin
            m_seen  = done;
            m_start = startq;
            return;
        end
        nx = m_ph; nt = m_turn; to = 0;
        attack = (m_ph == PLAYER_ATK) || (m_ph == ENEMY_ATK);
        if (attack) m_frames++;
        expired = attack && (TO != 0) && (m_frames == TO);
        if (m_ph == IDLE) begin
            if (startq) nx = PLAYER_ATK;
        end else if (m_ph == PLAYER_ATK) begin
            if (done && enemy_hp_zero_in) nx = WIN;
            else if (done || expired) begin nx = ENEMY_ATK; to = !done; end
        end else if (m_ph == ENEMY_ATK) begin
            if (player_hp_zero_in) nx = LOSE;
            else if (done || expired) begin
                nt = (m_turn < 255) ? m_turn + 1 : 255;
                to = !done;
                nx = (m_turn + 1 >= MT) ? WIN : PLAYER_ATK;
            end
        end else begin
            if (startq) begin nx = IDLE; nt = 0; end
        end
        m_start = 0;
        if (nx != m_ph) begin
            e.cyc = cyc + 1; e.st = nx; e.turn = 8'(nt); e.to = to;
            e.go  = (nx == WIN) || (nx == LOSE);
            sb.push_back(e);
            m_ph = nx; m_turn = nt; m_seen = 0; m_frames = 0;
        end else begin
            m_seen = done;
        end
    endtask

    // Emulates the attack blocks: a finish is raised at a random moment and held until the phase ends;
    // stray pulses on the idle block's finished line must be ignored
    task automatic drive();
        hcount_in = 11'(hc);
        vcount_in = 10'(vc);
        start_in  = ($urandom_range(0, 99) == 0);
        if (m_ph == PLAYER_ATK) begin
            if (!pf_on && $urandom_range(0, 199) == 0) pf_on = 1;
            player_finished_in = pf_on;
        end else begin
            pf_on = 0;
            player_finished_in = ($urandom_range(0, 39) == 0);
        end
        if (m_ph == ENEMY_ATK) begin
            if (!ef_on && $urandom_range(0, 199) == 0) ef_on = 1;
            enemy_finished_in = ef_on;
        end else begin
            ef_on = 0;
            enemy_finished_in = ($urandom_range(0, 39) == 0);
        end
        if (enemy_hp_zero_in) begin
            if ($urandom_range(0, 149) == 0) enemy_hp_zero_in = 1'b0;
        end else if ($urandom_range(0, 1499) == 0) enemy_hp_zero_in = 1'b1;
        if (player_hp_zero_in) begin
            if ($urandom_range(0, 149) == 0) player_hp_zero_in = 1'b0;
        end else if ($urandom_range(0, 1499) == 0) player_hp_zero_in = 1'b1;
    endtask

    task automatic check_reset(input string name);
        n_tests++;
        if (state_out !== 4'b0000) begin n_fail++; $display("FAIL %s state_out got %0h want 0", name, state_out); end
        n_tests++;
        if (turn_out !== 8'd0) begin n_fail++; $display("FAIL %s turn_out got %0d want 0", name, turn_out); end
        n_tests++;
        if (timeout_out !== 1'b0) begin n_fail++; $display("FAIL %s timeout_out got %0b want 0", name, timeout_out); end
        n_tests++;
        if (game_over_out !== 1'b0) begin n_fail++; $display("FAIL %s game_over_out got %0b want 0", name, game_over_out); end
    endtask

    // Monitor: any change of the outputs, or a timeout pulse, must match the next predicted transition
    logic [3:0] p_st;
    logic [7:0] p_turn;
    logic       p_go;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            p_st = state_out; p_turn = turn_out; p_go = game_over_out;
        end else begin
            if (sb.size() > 0 && sb[0].cyc < cyc) begin
                n_tests++; n_fail++;
                $display("FAIL missed_transition: edge %0d want st=%0h, outputs still st=%0h", sb[0].cyc, sb[0].st, state_out);
                void'(sb.pop_front());
            end
            if (state_out !== p_st || turn_out !== p_turn || game_over_out !== p_go || timeout_out !== 1'b0) begin
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_change at edge %0d: got st=%0h turn=%0d to=%0b go=%0b",
                             cyc, state_out, turn_out, timeout_out, game_over_out);
                end else begin
                    e = sb.pop_front();
                    if (e.cyc != cyc || e.st !== state_out || e.turn !== turn_out ||
                        e.to !== timeout_out || e.go !== game_over_out) begin
                        n_fail++;
                        $display("FAIL transition: got edge %0d st=%0h turn=%0d to=%0b go=%0b, want edge %0d st=%0h turn=%0d to=%0b go=%0b",
                                 cyc, state_out, turn_out, timeout_out, game_over_out,
                                 e.cyc, e.st, e.turn, e.to, e.go);
                    end
                end
            end
            p_st = state_out; p_turn = turn_out; p_go = game_over_out;
        end
    end

    initial begin
        int wait_cnt;
        bit want_rst;
        rst = 1'b0;
        hcount_in = '0; vcount_in = 10'd1;
        start_in = 0; player_finished_in = 0; enemy_finished_in = 0;
        enemy_hp_zero_in = 0; player_hp_zero_in = 0;
        hc = 0; vc = 1;
        model_reset();
        #1 rst = 1'b1;
        #2 check_reset("reset_init");
        @(posedge clk); #1;
        rst = 1'b0;
        want_rst = 0; wait_cnt = 0;
        for (int c = 0; c < NCYC; c++) begin
            if (c == 4000 || c == 8000 || c == 12000) begin want_rst = 1; wait_cnt = 0; end
            if (want_rst) wait_cnt++;
            // Asynchronous reset, preferably in the middle of an enemy attack
            if (want_rst && (m_ph == ENEMY_ATK || wait_cnt > 3000)) begin
                want_rst = 0;
                rst = 1'b1;
                #1 check_reset("reset_mid");
                sb.delete();
                model_reset();
                @(posedge clk); #1;
                rst = 1'b0;
            end
            drive();
            predict();
            @(posedge clk); #1;
            hc++;
            if (hc == H) begin
                hc = 0; vc++;
                if (vc == V) vc = 0;
            end
        end
        @(negedge clk); #1;
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL pending_transitions: got %0d left want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
